// File: rtl/burst_ram_pkg.sv
// Shared BurstRAM definitions: command encodings and the arbiter state set.
// Used by the caches, the arbiter and the BurstRAM model.
package burst_ram_pkg;

  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_RD_I   = 3'd1,
    ARB_RD_D   = 3'd2,
    ARB_WR_D   = 3'd3,
    ARB_REPLAY = 3'd4
  } arb_state_t;

  function automatic logic is_read_state(input arb_state_t s);
    return (s == ARB_RD_I) || (s == ARB_RD_D);
  endfunction

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and the BurstRAM port.
// slave = arbiter view, master = environment (caches + BurstRAM) view.
interface burst_ram_arbiter_if #(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64
);
  // instruction cache client
  logic                                 i_cmd_en;
  logic [RAM_DEPTH_BITWIDTH-1:0]        i_addr;
  logic [RAM_BURST_DATA_BITWIDTH-1:0]   i_rd_data;
  logic                                 i_rd_data_valid;
  logic                                 i_busy;
  // data cache client
  logic                                 d_cmd;
  logic                                 d_cmd_en;
  logic [RAM_DEPTH_BITWIDTH-1:0]        d_addr;
  logic [RAM_BURST_DATA_BITWIDTH-1:0]   d_wr_data;
  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] d_data_mask;
  logic [RAM_BURST_DATA_BITWIDTH-1:0]   d_rd_data;
  logic                                 d_rd_data_valid;
  logic                                 d_busy;
  // BurstRAM port
  logic                                 br_cmd;
  logic                                 br_cmd_en;
  logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr;
  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data;
  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask;
  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data;
  logic                                 br_rd_data_valid;
  logic                                 br_busy;

  modport slave (
    input  i_cmd_en, i_addr,
    output i_rd_data, i_rd_data_valid, i_busy,
    input  d_cmd, d_cmd_en, d_addr, d_wr_data, d_data_mask,
    output d_rd_data, d_rd_data_valid, d_busy,
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid, br_busy
  );

  modport master (
    output i_cmd_en, i_addr,
    input  i_rd_data, i_rd_data_valid, i_busy,
    output d_cmd, d_cmd_en, d_addr, d_wr_data, d_data_mask,
    input  d_rd_data, d_rd_data_valid, d_busy,
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid, br_busy
  );

endinterface

// File: rtl/burst_ram_arbiter_beat_counter.sv
// Beat counter for one burst: counts up on inc, wraps to 0 after the last beat.
// done flags that the current beat is the final one (index COUNT-1).
module burst_beat_counter #(
  parameter int COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);
  localparam int CNT_BW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_BW-1:0] LAST = CNT_BW'(COUNT - 1);

  logic [CNT_BW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign done = (r_count == LAST);

endmodule

// File: rtl/burst_ram_arbiter.sv
// Two-client arbiter in front of the single BurstRAM port: D has fixed priority,
// a colliding I request is parked and replayed once the D burst completes.
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64
) (
  input logic                clk,
  input logic                rst,
  burst_ram_arbiter_if.slave bus
);
  localparam int MASK_BW = RAM_BURST_DATA_BITWIDTH / 8;

  arb_state_t                    r_state;
  logic                          r_pending_valid;
  logic [RAM_DEPTH_BITWIDTH-1:0] r_pending_addr;

  logic w_idle_ok, w_d_go, w_i_go, w_replay_go;
  logic w_wr_beat, w_rd_beat, w_beat_inc, w_beat_done, w_burst_end, w_cnt_clr;
  logic w_busy;
  logic [RAM_DEPTH_BITWIDTH-1:0]      w_addr;
  logic [RAM_BURST_DATA_BITWIDTH-1:0] w_wr_data;
  logic [MASK_BW-1:0]                 w_mask;

  // Winner selection is purely combinational so a request reaches BurstRAM in its own cycle.
  assign w_idle_ok   = !rst && !bus.br_busy && (r_state == ARB_IDLE);
  assign w_d_go      = w_idle_ok && bus.d_cmd_en;
  assign w_i_go      = w_idle_ok && bus.i_cmd_en && !bus.d_cmd_en;
  assign w_replay_go = !rst && !bus.br_busy && (r_state == ARB_REPLAY);

  assign w_wr_beat   = !rst && ((w_d_go && (bus.d_cmd == BR_CMD_WRITE)) || (r_state == ARB_WR_D));
  assign w_rd_beat   = !rst && is_read_state(r_state) && bus.br_rd_data_valid;
  assign w_beat_inc  = w_wr_beat || w_rd_beat;
  assign w_burst_end = w_beat_inc && w_beat_done;
  assign w_cnt_clr   = ((r_state == ARB_IDLE) && !w_wr_beat) || (r_state == ARB_REPLAY);

  burst_beat_counter #(
    .COUNT (RAM_BURST_DATA_COUNT)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_cnt_clr),
    .inc  (w_beat_inc),
    .done (w_beat_done)
  );

  always_comb begin
    w_addr = '0;
    if (w_d_go) begin
      w_addr = bus.d_addr;
    end else if (w_i_go) begin
      w_addr = bus.i_addr;
    end else if (w_replay_go) begin
      w_addr = r_pending_addr;
    end
  end

  // Write beats pass straight through; outside a write the mask protects every byte.
  assign w_wr_data = w_wr_beat ? bus.d_wr_data : '0;
  assign w_mask    = w_wr_beat ? bus.d_data_mask : '1;

  assign bus.br_cmd_en    = w_d_go || w_i_go || w_replay_go;
  assign bus.br_cmd       = w_wr_beat ? BR_CMD_WRITE : BR_CMD_READ;
  assign bus.br_addr      = w_addr;
  assign bus.br_wr_data   = w_wr_data;
  assign bus.br_data_mask = w_mask;

  assign bus.i_rd_data       = bus.br_rd_data;
  assign bus.d_rd_data       = bus.br_rd_data;
  assign bus.i_rd_data_valid = w_rd_beat && (r_state == ARB_RD_I);
  assign bus.d_rd_data_valid = w_rd_beat && (r_state == ARB_RD_D);

  assign w_busy     = rst || bus.br_busy || (r_state != ARB_IDLE) || r_pending_valid;
  assign bus.i_busy = w_busy;
  assign bus.d_busy = w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ARB_IDLE;
      r_pending_valid <= 1'b0;
      r_pending_addr  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_d_go) begin
            r_state <= (bus.d_cmd == BR_CMD_WRITE) ? ARB_WR_D : ARB_RD_D;
            if (bus.i_cmd_en) begin
              r_pending_valid <= 1'b1;
              r_pending_addr  <= bus.i_addr;
            end
          end else if (w_i_go) begin
            r_state <= ARB_RD_I;
          end
        end
        ARB_RD_I, ARB_RD_D, ARB_WR_D: begin
          if (w_burst_end) begin
            r_state <= r_pending_valid ? ARB_REPLAY : ARB_IDLE;
          end
        end
        ARB_REPLAY: begin
          if (w_replay_go) begin
            r_state         <= ARB_RD_I;
            r_pending_valid <= 1'b0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: BurstRAM behavioural model plus a transaction-level
// memory image that predicts every beat each client should receive.
module tb_burst_ram_arbiter;
  import burst_ram_pkg::*;

  localparam int DW    = 4;
  localparam int CNT   = 4;
  localparam int BW    = 64;
  localparam int MW    = BW / 8;
  localparam int DEPTH = 1 << DW;

  typedef logic [BW-1:0] burst_t [CNT];
  typedef logic [MW-1:0] maskb_t [CNT];
  typedef logic [DW:0]   cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_ram_arbiter_if #(.RAM_DEPTH_BITWIDTH(DW), .RAM_BURST_DATA_BITWIDTH(BW)) bus ();

  burst_ram_arbiter #(
    .RAM_DEPTH_BITWIDTH      (DW),
    .RAM_BURST_DATA_COUNT    (CNT),
    .RAM_BURST_DATA_BITWIDTH (BW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int issue_cyc = 0;
  logic [63:0] seed;
  logic [BW-1:0] ref_mem [DEPTH][CNT];

  function automatic logic [BW-1:0] init_word(input int a, input int b);
    return seed ^ (64'(a * CNT + b) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic logic [BW-1:0] merge(input logic [BW-1:0] old_w, input logic [BW-1:0] new_w,
                                          input logic [MW-1:0] m);
    logic [BW-1:0] r;
    for (int k = 0; k < MW; k++) r[k*8 +: 8] = m[k] ? old_w[k*8 +: 8] : new_w[k*8 +: 8];
    return r;
  endfunction

  // ---------------- BurstRAM model ----------------
  logic [BW-1:0] ram [DEPTH][CNT];
  logic          ram_loaded = 1'b0;
  logic          m_rd_active, m_rd_valid;
  logic [BW-1:0] m_rd_data;
  logic [DW-1:0] m_rd_addr, m_wr_addr;
  int            m_rd_idx, m_rd_wait, m_wr_left;
  logic          force_busy = 1'b0;
  logic          spur_valid = 1'b0;

  assign bus.br_busy          = force_busy | m_rd_active | (m_wr_left != 0);
  assign bus.br_rd_data_valid = m_rd_valid | spur_valid;
  assign bus.br_rd_data       = m_rd_data;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!ram_loaded) begin
      for (int a = 0; a < DEPTH; a++)
        for (int b = 0; b < CNT; b++) ram[a][b] <= init_word(a, b);
      ram_loaded <= 1'b1;
    end
    if (rst) begin
      m_rd_active <= 1'b0;
      m_rd_valid  <= 1'b0;
      m_rd_data   <= '0;
      m_wr_left   <= 0;
      m_rd_idx    <= 0;
      m_rd_wait   <= 0;
    end else begin
      m_rd_valid <= 1'b0;
      if (bus.br_cmd_en && bus.br_cmd == BR_CMD_WRITE) begin
        ram[bus.br_addr][0] <= merge(ram[bus.br_addr][0], bus.br_wr_data, bus.br_data_mask);
        m_wr_addr <= bus.br_addr;
        m_wr_left <= CNT - 1;
      end else if (m_wr_left != 0) begin
        ram[m_wr_addr][CNT-m_wr_left] <= merge(ram[m_wr_addr][CNT-m_wr_left], bus.br_wr_data, bus.br_data_mask);
        m_wr_left <= m_wr_left - 1;
      end
      if (bus.br_cmd_en && bus.br_cmd == BR_CMD_READ) begin
        m_rd_active <= 1'b1;
        m_rd_addr   <= bus.br_addr;
        m_rd_idx    <= 0;
        m_rd_wait   <= int'($urandom_range(0, 2));
      end else if (m_rd_active) begin
        if (m_rd_wait != 0) begin
          m_rd_wait <= m_rd_wait - 1;
        end else if ($urandom_range(0, 3) != 0) begin
          m_rd_valid <= 1'b1;
          m_rd_data  <= ram[m_rd_addr][m_rd_idx];
          m_rd_idx   <= m_rd_idx + 1;
          if (m_rd_idx == CNT - 1) m_rd_active <= 1'b0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  logic [BW-1:0]    i_got[$], d_got[$];
  cmd_t             cmd_log[$];
  int               cmd_cyc[$];
  logic [BW+MW-1:0] wr_log[$];
  int               mon_wr_left = 0;

  always @(negedge clk) begin
    if (bus.i_rd_data_valid) i_got.push_back(bus.i_rd_data);
    if (bus.d_rd_data_valid) d_got.push_back(bus.d_rd_data);
    if (bus.br_cmd_en) begin
      cmd_log.push_back({bus.br_cmd, bus.br_addr});
      cmd_cyc.push_back(cyc_cnt);
    end
    if (rst) begin
      mon_wr_left <= 0;
    end else if (bus.br_cmd_en && bus.br_cmd == BR_CMD_WRITE) begin
      wr_log.push_back({bus.br_wr_data, bus.br_data_mask});
      mon_wr_left <= CNT - 1;
    end else if (mon_wr_left > 0) begin
      wr_log.push_back({bus.br_wr_data, bus.br_data_mask});
      mon_wr_left <= mon_wr_left - 1;
    end
  end

  // ---------------- drivers ----------------
  task automatic clear_logs();
    i_got.delete(); d_got.delete(); cmd_log.delete(); cmd_cyc.delete(); wr_log.delete();
  endtask

  task automatic issue(input bit i_en, input logic [DW-1:0] ia, input bit d_en, input bit d_wr,
                       input logic [DW-1:0] da, input burst_t wd, input maskb_t wm);
    @(posedge clk); #1;
    issue_cyc       = cyc_cnt;
    bus.i_cmd_en    = i_en;
    bus.i_addr      = ia;
    bus.d_cmd_en    = d_en;
    bus.d_cmd       = d_wr;
    bus.d_addr      = da;
    bus.d_wr_data   = wd[0];
    bus.d_data_mask = wm[0];
    for (int b = 1; b < CNT; b++) begin
      @(posedge clk); #1;
      bus.i_cmd_en    = 1'b0;
      bus.d_cmd_en    = 1'b0;
      bus.d_wr_data   = wd[b];
      bus.d_data_mask = wm[b];
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (!bus.i_busy && !bus.d_busy) ok = 1'b1;
    end
  endtask

  task automatic wait_beats(input int ni, input int nd, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); #1;
      if (i_got.size() >= ni && d_got.size() >= nd) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clk);
    checks++; if (bus.br_cmd_en !== 1'b0) begin failures++; $display("FAIL rst_cmd_en: got %b want 0", bus.br_cmd_en); end
    checks++; if (bus.br_cmd !== 1'b0) begin failures++; $display("FAIL rst_cmd: got %b want 0", bus.br_cmd); end
    checks++; if (bus.br_addr !== '0) begin failures++; $display("FAIL rst_addr: got %h want 0", bus.br_addr); end
    checks++; if (bus.br_data_mask !== '1) begin failures++; $display("FAIL rst_mask: got %h want ff", bus.br_data_mask); end
    checks++; if ({bus.i_rd_data_valid, bus.d_rd_data_valid} !== 2'b00) begin failures++; $display("FAIL rst_valid: got %b want 00", {bus.i_rd_data_valid, bus.d_rd_data_valid}); end
    checks++; if ({bus.i_busy, bus.d_busy} !== 2'b11) begin failures++; $display("FAIL rst_busy: got %b want 11", {bus.i_busy, bus.d_busy}); end
    @(posedge clk); #1 rst = 1'b0;
    wait_quiet(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL post_rst_busy: got %b want 00", {bus.i_busy, bus.d_busy}); end
    $display("reset: done");
  endtask

  task automatic test_i_read_alone();
    bit ok; burst_t wd; maskb_t wm;
    for (int b = 0; b < CNT; b++) begin wd[b] = '0; wm[b] = '1; end
    wait_quiet(100, ok);
    clear_logs();
    issue(1'b1, DW'(3), 1'b0, 1'b0, '0, wd, wm);
    wait_beats(CNT, 0, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL i_read_timeout: got %0d beats want %0d", i_got.size(), CNT); end
    checks++;
    if (cmd_log.size() != 1 || cmd_log[0] !== {BR_CMD_READ, DW'(3)}) begin
      failures++; $display("FAIL i_read_cmd: got %0d cmds first %h want 1 cmd %h", cmd_log.size(), (cmd_log.size() > 0) ? cmd_log[0] : '0, {BR_CMD_READ, DW'(3)});
    end
    checks++;
    if (cmd_cyc.size() < 1 || cmd_cyc[0] != issue_cyc) begin
      failures++; $display("FAIL i_read_latency: got cycle %0d want %0d", (cmd_cyc.size() > 0) ? cmd_cyc[0] : -1, issue_cyc);
    end
    repeat (6) @(negedge clk);
    checks++; if (i_got.size() != CNT || d_got.size() != 0) begin failures++; $display("FAIL i_read_routing: got i=%0d d=%0d want i=%0d d=0", i_got.size(), d_got.size(), CNT); end
    for (int b = 0; b < CNT && b < i_got.size(); b++) begin
      checks++; if (i_got[b] !== ref_mem[3][b]) begin failures++; $display("FAIL i_read_beat%0d: got %h want %h", b, i_got[b], ref_mem[3][b]); end
    end
    checks++; if (bus.i_busy !== 1'b0) begin failures++; $display("FAIL i_read_busy_after: got %b want 0", bus.i_busy); end
    $display("i_read @3: %0d beats", i_got.size());
  endtask

  task automatic test_collision();
    bit ok; burst_t wd; maskb_t wm;
    for (int b = 0; b < CNT; b++) begin wd[b] = '0; wm[b] = '1; end
    wait_quiet(100, ok);
    clear_logs();
    issue(1'b1, DW'(5), 1'b1, 1'b0, DW'(9), wd, wm);
    wait_beats(CNT, CNT, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL collide_timeout: got i=%0d d=%0d want %0d each", i_got.size(), d_got.size(), CNT); end
    checks++;
    if (cmd_log.size() != 2 || cmd_log[0] !== {BR_CMD_READ, DW'(9)} || cmd_log[1] !== {BR_CMD_READ, DW'(5)}) begin
      failures++; $display("FAIL collide_order: got %0d cmds want D@9 then I@5", cmd_log.size());
    end
    checks++; if (cmd_cyc.size() < 1 || cmd_cyc[0] != issue_cyc) begin failures++; $display("FAIL collide_latency: got %0d want %0d", (cmd_cyc.size() > 0) ? cmd_cyc[0] : -1, issue_cyc); end
    for (int b = 0; b < CNT && b < d_got.size(); b++) begin
      checks++; if (d_got[b] !== ref_mem[9][b]) begin failures++; $display("FAIL collide_d_beat%0d: got %h want %h", b, d_got[b], ref_mem[9][b]); end
    end
    for (int b = 0; b < CNT && b < i_got.size(); b++) begin
      checks++; if (i_got[b] !== ref_mem[5][b]) begin failures++; $display("FAIL collide_i_beat%0d: got %h want %h", b, i_got[b], ref_mem[5][b]); end
    end
    $display("collision I@5 D@9: cmds=%0d i=%0d d=%0d", cmd_log.size(), i_got.size(), d_got.size());
  endtask

  task automatic test_write();
    bit ok; burst_t wd; maskb_t wm;
    for (int b = 0; b < CNT; b++) begin wd[b] = BW'((b + 1) * 'h11); wm[b] = '0; end
    wait_quiet(100, ok);
    clear_logs();
    issue(1'b0, '0, 1'b1, 1'b1, DW'(2), wd, wm);
    @(negedge clk);
    checks++; if (bus.br_data_mask !== '1) begin failures++; $display("FAIL write_mask_idle: got %h want ff", bus.br_data_mask); end
    checks++; if (cmd_log.size() != 1 || cmd_log[0] !== {BR_CMD_WRITE, DW'(2)}) begin failures++; $display("FAIL write_cmd: got %0d cmds want 1 write @2", cmd_log.size()); end
    checks++; if (wr_log.size() != CNT) begin failures++; $display("FAIL write_beats: got %0d want %0d", wr_log.size(), CNT); end
    for (int b = 0; b < CNT && b < wr_log.size(); b++) begin
      checks++; if (wr_log[b] !== {wd[b], wm[b]}) begin failures++; $display("FAIL write_beat%0d: got %h want %h", b, wr_log[b], {wd[b], wm[b]}); end
    end
    for (int b = 0; b < CNT; b++) ref_mem[2][b] = merge(ref_mem[2][b], wd[b], wm[b]);
    $display("d_write @2: %0d beats forwarded", wr_log.size());
  endtask

  task automatic test_busy_drop();
    bit ok; burst_t wd; maskb_t wm;
    for (int b = 0; b < CNT; b++) begin wd[b] = '0; wm[b] = '1; end
    wait_quiet(100, ok);
    clear_logs();
    force_busy = 1'b1;
    @(negedge clk);
    checks++; if ({bus.i_busy, bus.d_busy} !== 2'b11) begin failures++; $display("FAIL br_busy_visible: got %b want 11", {bus.i_busy, bus.d_busy}); end
    @(posedge clk); #1;
    bus.i_cmd_en = 1'b1; bus.i_addr = DW'(7); bus.d_cmd_en = 1'b1; bus.d_cmd = 1'b0; bus.d_addr = DW'(1);
    @(negedge clk);
    checks++; if (bus.br_cmd_en !== 1'b0) begin failures++; $display("FAIL busy_drop_cmd_en: got %b want 0", bus.br_cmd_en); end
    @(posedge clk); #1;
    bus.i_cmd_en = 1'b0; bus.d_cmd_en = 1'b0;
    @(posedge clk); #1 force_busy = 1'b0;
    spur_valid = 1'b1;
    @(negedge clk);
    checks++; if ({bus.i_rd_data_valid, bus.d_rd_data_valid} !== 2'b00) begin failures++; $display("FAIL spurious_valid: got %b want 00", {bus.i_rd_data_valid, bus.d_rd_data_valid}); end
    @(posedge clk); #1 spur_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (cmd_log.size() != 0 || i_got.size() != 0 || d_got.size() != 0) begin failures++; $display("FAIL busy_drop_effect: got cmds=%0d i=%0d d=%0d want 0", cmd_log.size(), i_got.size(), d_got.size()); end
    checks++; if ({bus.i_busy, bus.d_busy} !== 2'b00) begin failures++; $display("FAIL busy_drop_idle: got %b want 00", {bus.i_busy, bus.d_busy}); end
    $display("busy drop: cmds=%0d", cmd_log.size());
  endtask

  task automatic test_reset_mid();
    bit ok; burst_t wd; maskb_t wm;
    logic [DW-1:0] da;
    for (int b = 0; b < CNT; b++) begin wd[b] = '0; wm[b] = '1; end
    da = DW'($urandom);
    wait_quiet(100, ok);
    clear_logs();
    issue(1'b1, DW'($urandom), 1'b1, 1'b0, da, wd, wm);
    wait_beats(0, 2, 200, ok);
    checks++; if (!ok || d_got.size() != 2) begin failures++; $display("FAIL midrst_setup: got %0d d beats want 2", d_got.size()); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.i_rd_data_valid, bus.d_rd_data_valid} !== 2'b00) begin failures++; $display("FAIL midrst_valid: got %b want 00", {bus.i_rd_data_valid, bus.d_rd_data_valid}); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.i_busy, bus.d_busy} !== 2'b00) begin failures++; $display("FAIL midrst_idle: got %b want 00", {bus.i_busy, bus.d_busy}); end
    repeat (10) @(negedge clk);
    checks++; if (cmd_log.size() != 1 || i_got.size() != 0 || d_got.size() != 2) begin failures++; $display("FAIL midrst_abort: got cmds=%0d i=%0d d=%0d want 1/0/2", cmd_log.size(), i_got.size(), d_got.size()); end
    $display("mid-burst reset @%0d: d beats=%0d", da, d_got.size());
  endtask

  task automatic test_back_to_back();
    bit ok; burst_t wd; maskb_t wm;
    logic [DW-1:0] a;
    a = DW'($urandom);
    for (int b = 0; b < CNT; b++) begin wd[b] = {$urandom, $urandom}; wm[b] = MW'($urandom); end
    wait_quiet(100, ok);
    clear_logs();
    issue(1'b0, '0, 1'b1, 1'b1, a, wd, wm);
    for (int b = 0; b < CNT; b++) ref_mem[a][b] = merge(ref_mem[a][b], wd[b], wm[b]);
    wait_quiet(50, ok);
    issue(1'b0, '0, 1'b1, 1'b0, a, wd, wm);
    wait_beats(0, CNT, 200, ok);
    checks++; if (!ok || i_got.size() != 0) begin failures++; $display("FAIL b2b_beats: got i=%0d d=%0d want 0/%0d", i_got.size(), d_got.size(), CNT); end
    for (int b = 0; b < CNT && b < d_got.size(); b++) begin
      checks++; if (d_got[b] !== ref_mem[a][b]) begin failures++; $display("FAIL b2b_beat%0d: got %h want %h", b, d_got[b], ref_mem[a][b]); end
    end
    $display("back-to-back write/read @%0d: %0d beats", a, d_got.size());
  endtask

  task automatic test_random();
    bit ok, i_en, d_en, d_wr; burst_t wd; maskb_t wm;
    logic [DW-1:0] ia, da;
    int op, ni, nd;
    for (int n = 0; n < 20; n++) begin
      op = int'($urandom_range(0, 3));
      ia = DW'($urandom); da = DW'($urandom);
      for (int b = 0; b < CNT; b++) begin wd[b] = {$urandom, $urandom}; wm[b] = MW'($urandom); end
      i_en = (op == 0) || (op == 3);
      d_en = (op != 0);
      d_wr = (op == 2) || ((op == 3) && ($urandom_range(0, 1) == 1));
      ni = i_en ? CNT : 0;
      nd = (d_en && !d_wr) ? CNT : 0;
      wait_quiet(100, ok);
      clear_logs();
      issue(i_en, ia, d_en, d_wr, da, wd, wm);
      if (d_en && d_wr)
        for (int b = 0; b < CNT; b++) ref_mem[da][b] = merge(ref_mem[da][b], wd[b], wm[b]);
      wait_beats(ni, nd, 300, ok);
      wait_quiet(100, ok);
      checks++; if (!ok || i_got.size() != ni || d_got.size() != nd) begin failures++; $display("FAIL rnd%0d_count: got i=%0d d=%0d want %0d/%0d", n, i_got.size(), d_got.size(), ni, nd); end
      for (int b = 0; b < CNT && b < i_got.size(); b++) begin
        checks++; if (i_got[b] !== ref_mem[ia][b]) begin failures++; $display("FAIL rnd%0d_i_beat%0d: got %h want %h", n, b, i_got[b], ref_mem[ia][b]); end
      end
      for (int b = 0; b < CNT && b < d_got.size(); b++) begin
        checks++; if (d_got[b] !== ref_mem[da][b]) begin failures++; $display("FAIL rnd%0d_d_beat%0d: got %h want %h", n, b, d_got[b], ref_mem[da][b]); end
      end
      if (i_en && d_en) begin
        checks++; if (cmd_log.size() != 2 || cmd_log[1] !== {BR_CMD_READ, ia}) begin failures++; $display("FAIL rnd%0d_replay: got %0d cmds want replay of I@%0d", n, cmd_log.size(), ia); end
      end
      $display("rnd %0d: op=%0d ia=%0d da=%0d wr=%0d i=%0d d=%0d", n, op, ia, da, d_wr, i_got.size(), d_got.size());
    end
  endtask

  initial begin
    seed = {$urandom, $urandom};
    for (int a = 0; a < DEPTH; a++)
      for (int b = 0; b < CNT; b++) ref_mem[a][b] = init_word(a, b);
    bus.i_cmd_en = 1'b0; bus.i_addr = '0;
    bus.d_cmd_en = 1'b0; bus.d_cmd = 1'b0; bus.d_addr = '0;
    bus.d_wr_data = '0; bus.d_data_mask = '1;
    test_reset();
    test_i_read_alone();
    test_collision();
    test_write();
    test_busy_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
